// File: rtl/tl_pkg.sv
// Shared opcodes, entry-state encoding and opcode helpers for the manager-side source tracker.
package tl_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] A_PUT_FULL_DATA = 3'd0;
  localparam logic [OP_W-1:0] A_GET           = 3'd4;
  localparam logic [OP_W-1:0] A_ACQUIRE_BLOCK = 3'd6;

  localparam logic [OP_W-1:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [OP_W-1:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [OP_W-1:0] D_GRANT_DATA      = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUED   = 2'd1,
    ST_RESP     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } entry_state_e;

  function automatic logic a_supported(input logic [OP_W-1:0] op);
    return (op == A_PUT_FULL_DATA) || (op == A_GET) || (op == A_ACQUIRE_BLOCK);
  endfunction

  // Unsupported requests are answered like a Get (with denied set by the caller).
  function automatic logic [OP_W-1:0] d_opcode_for(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] d_op;
    d_op = D_ACCESS_ACK_DATA;
    if (op == A_PUT_FULL_DATA) d_op = D_ACCESS_ACK;
    if (op == A_ACQUIRE_BLOCK) d_op = D_GRANT_DATA;
    return d_op;
  endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Synchronous response FIFO with valid/ready pop; DEPTH must be a power of two.
module tl_resp_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push_en;
  logic             pop_en;

  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign push_en   = push & ~full;
  assign pop_en    = pop_valid & pop_ready;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // At most one response per source can be queued, so a push into a full FIFO is a design bug.
  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/tl_source_tracker.sv
// Manager-side per-source transaction table: A requests to backend, completions back out on D,
// GrantData sources held until GrantAck on E.
module tl_source_tracker
  import tl_pkg::*;
#(
  parameter int unsigned SRC_W  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [OP_W-1:0]   a_opcode,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [OP_W-1:0]   mem_req_opcode,
  output logic [SRC_W-1:0]  mem_req_source,
  output logic [ADDR_W-1:0] mem_req_address,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_rsp_valid,
  input  logic [SRC_W-1:0]  mem_rsp_source,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [OP_W-1:0]   d_opcode,
  output logic [SRC_W-1:0]  d_source,
  output logic [SRC_W-1:0]  d_sink,
  output logic              d_denied,
  output logic [DATA_W-1:0] d_data,
  input  logic              e_valid,
  input  logic [SRC_W-1:0]  e_sink,
  output logic [SRC_W:0]    outstanding,
  output logic              proto_err
);

  localparam int unsigned NUM_SRC = 2**SRC_W;
  localparam int unsigned RSP_W   = SRC_W + OP_W + 1 + DATA_W;

  entry_state_e    state_q [NUM_SRC];
  entry_state_e    state_d [NUM_SRC];
  logic [OP_W-1:0] dop_q   [NUM_SRC];
  logic [OP_W-1:0] dop_d   [NUM_SRC];
  logic            den_q   [NUM_SRC];
  logic            den_d   [NUM_SRC];

  logic             src_idle;
  logic             a_supp;
  logic             a_fire;
  logic             rsp_hit;
  logic             d_fire;
  logic             err_set;
  logic [SRC_W:0]   busy_cnt;
  logic [RSP_W-1:0] rsp_push_data;
  logic [RSP_W-1:0] rsp_head;
  logic [DATA_W-1:0] rsp_data;

  // A path is combinational against the registered table.
  assign src_idle        = (state_q[a_source] == ST_IDLE);
  assign a_supp          = a_supported(a_opcode);
  assign mem_req_valid   = a_valid & src_idle;
  assign a_ready         = mem_req_ready & src_idle;
  assign mem_req_opcode  = a_supp ? a_opcode : A_GET;
  assign mem_req_source  = a_source;
  assign mem_req_address = a_address;
  assign mem_req_data    = a_data;
  assign a_fire          = a_valid & a_ready;

  assign rsp_hit  = mem_rsp_valid & (state_q[mem_rsp_source] == ST_ISSUED);
  assign rsp_data = (dop_q[mem_rsp_source] == D_ACCESS_ACK) ? '0 : mem_rsp_data;
  assign rsp_push_data = {mem_rsp_source, dop_q[mem_rsp_source], den_q[mem_rsp_source], rsp_data};

  tl_resp_fifo #(
    .DEPTH (NUM_SRC),
    .WIDTH (RSP_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_hit),
    .push_data (rsp_push_data),
    .pop_valid (d_valid),
    .pop_ready (d_ready),
    .pop_data  (rsp_head)
  );

  assign {d_source, d_opcode, d_denied, d_data} = rsp_head;
  assign d_sink = d_source;
  assign d_fire = d_valid & d_ready;

  // Table next state; D fire is applied after mem_rsp so it wins on a shared entry.
  always_comb begin
    state_d  = state_q;
    dop_d    = dop_q;
    den_d    = den_q;
    err_set  = 1'b0;
    busy_cnt = '0;
    if (a_fire) begin
      state_d[a_source] = ST_ISSUED;
      dop_d[a_source]   = d_opcode_for(a_opcode);
      den_d[a_source]   = ~a_supp;
      if (!a_supp) err_set = 1'b1;
    end
    if (mem_rsp_valid) begin
      if (rsp_hit) state_d[mem_rsp_source] = ST_RESP;
      else         err_set = 1'b1;
    end
    if (d_fire) begin
      state_d[d_source] = (d_opcode == D_GRANT_DATA) ? ST_WAIT_ACK : ST_IDLE;
    end
    if (e_valid) begin
      if (state_q[e_sink] == ST_WAIT_ACK) state_d[e_sink] = ST_IDLE;
      else                                err_set = 1'b1;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      busy_cnt = busy_cnt + (SRC_W+1)'(state_d[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= ST_IDLE;
        dop_q[i]   <= D_ACCESS_ACK;
        den_q[i]   <= 1'b0;
      end
      outstanding <= '0;
      proto_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dop_q       <= dop_d;
      den_q       <= den_d;
      outstanding <= busy_cnt;
      proto_err   <= proto_err | err_set;
    end
  end

endmodule

// File: tb/tb_tl_source_tracker.sv
// Directed bench for tl_source_tracker with hand-computed expectations.
module tb_tl_source_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [3:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [63:0] a_data = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [2:0]  mem_req_opcode;
  logic [3:0]  mem_req_source;
  logic [31:0] mem_req_address;
  logic [63:0] mem_req_data;
  logic        mem_rsp_valid = 1'b0;
  logic [3:0]  mem_rsp_source = '0;
  logic [63:0] mem_rsp_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [3:0]  d_source;
  logic [3:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        e_valid = 1'b0;
  logic [3:0]  e_sink = '0;
  logic [4:0]  outstanding;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tl_source_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .a_valid         (a_valid),
    .a_ready         (a_ready),
    .a_opcode        (a_opcode),
    .a_source        (a_source),
    .a_address       (a_address),
    .a_data          (a_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_opcode  (mem_req_opcode),
    .mem_req_source  (mem_req_source),
    .mem_req_address (mem_req_address),
    .mem_req_data    (mem_req_data),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_source  (mem_rsp_source),
    .mem_rsp_data    (mem_rsp_data),
    .d_valid         (d_valid),
    .d_ready         (d_ready),
    .d_opcode        (d_opcode),
    .d_source        (d_source),
    .d_sink          (d_sink),
    .d_denied        (d_denied),
    .d_data          (d_data),
    .e_valid         (e_valid),
    .e_sink          (e_sink),
    .outstanding     (outstanding),
    .proto_err       (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one A request and hold it until accepted (bounded).
  task automatic send_a(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr);
    int n;
    a_valid = 1'b1; a_opcode = op; a_source = src; a_address = addr; a_data = 64'(addr) ^ 64'hDEAD;
    #1;
    n = 0;
    while (!a_ready && n < 20) begin
      tick();
      n++;
    end
    if (!a_ready) check("a_accept_timeout", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [3:0] src, input logic [63:0] data);
    mem_rsp_valid = 1'b1; mem_rsp_source = src; mem_rsp_data = data;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic fire_d();
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_d_valid", 64'(d_valid), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);

    // Get src=3 addr=0x100
    a_valid = 1'b1; a_opcode = 3'd4; a_source = 4'd3; a_address = 32'h100; a_data = 64'h0;
    #1;
    check("get_req_valid", 64'(mem_req_valid), 64'd1);
    check("get_a_ready", 64'(a_ready), 64'd1);
    check("get_req_opcode", 64'(mem_req_opcode), 64'd4);
    check("get_req_source", 64'(mem_req_source), 64'd3);
    check("get_req_addr", 64'(mem_req_address), 64'h100);
    tick();
    a_valid = 1'b0;
    check("get_outstanding1", 64'(outstanding), 64'd1);
    send_rsp(4'd3, 64'hA5);
    check("get_d_valid", 64'(d_valid), 64'd1);
    check("get_d_opcode", 64'(d_opcode), 64'd1);
    check("get_d_source", 64'(d_source), 64'd3);
    check("get_d_data", 64'(d_data), 64'hA5);
    check("get_d_denied", 64'(d_denied), 64'd0);
    fire_d();
    check("get_d_drained", 64'(d_valid), 64'd0);
    check("get_outstanding0", 64'(outstanding), 64'd0);

    // AcquireBlock src=5, GrantData, hold until GrantAck
    send_a(3'd6, 4'd5, 32'h200);
    send_rsp(4'd5, 64'h55);
    check("acq_d_opcode", 64'(d_opcode), 64'd5);
    check("acq_d_sink", 64'(d_sink), 64'd5);
    check("acq_d_data", 64'(d_data), 64'h55);
    fire_d();
    check("acq_outstanding_hold", 64'(outstanding), 64'd1);
    a_valid = 1'b1; a_opcode = 3'd4; a_source = 4'd5; a_address = 32'h204;
    #1;
    check("acq_busy_a_ready", 64'(a_ready), 64'd0);
    check("acq_busy_req_valid", 64'(mem_req_valid), 64'd0);
    tick();
    check("acq_busy_a_ready2", 64'(a_ready), 64'd0);
    e_valid = 1'b1; e_sink = 4'd5;
    #1;
    check("acq_e_cycle_a_ready", 64'(a_ready), 64'd0);
    tick();
    e_valid = 1'b0;
    check("acq_after_e_outstanding", 64'(outstanding), 64'd0);
    check("acq_after_e_a_ready", 64'(a_ready), 64'd1);
    check("acq_after_e_req_valid", 64'(mem_req_valid), 64'd1);
    check("acq_proto_err", 64'(proto_err), 64'd0);
    tick();
    a_valid = 1'b0;
    check("acq_reissue_outstanding", 64'(outstanding), 64'd1);
    send_rsp(4'd5, 64'h66);
    check("acq_reissue_d_opcode", 64'(d_opcode), 64'd1);
    fire_d();
    check("acq_reissue_done", 64'(outstanding), 64'd0);

    // Fill all 16 sources, complete in reverse order while D is stalled
    for (int s = 0; s < 16; s++) send_a(3'd4, 4'(s), 32'(s * 64));
    check("fill_outstanding", 64'(outstanding), 64'd16);
    for (int s = 15; s >= 0; s--) send_rsp(4'(s), 64'h1000 + 64'(s));
    check("fill_outstanding_q", 64'(outstanding), 64'd16);
    check("fill_d_valid", 64'(d_valid), 64'd1);
    check("fill_head_stable", 64'(d_source), 64'd15);
    d_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 64'(d_valid), 64'd1);
      check("drain_source", 64'(d_source), 64'(15 - i));
      check("drain_data", d_data, 64'h1000 + 64'(15 - i));
      tick();
    end
    d_ready = 1'b0;
    check("drain_empty", 64'(d_valid), 64'd0);
    check("drain_outstanding", 64'(outstanding), 64'd0);
    check("drain_proto_err", 64'(proto_err), 64'd0);

    // Unsupported opcode 7 on src=2
    a_valid = 1'b1; a_opcode = 3'd7; a_source = 4'd2; a_address = 32'h300;
    #1;
    check("bad_op_req_opcode", 64'(mem_req_opcode), 64'd4);
    tick();
    a_valid = 1'b0;
    check("bad_op_proto_err", 64'(proto_err), 64'd1);
    send_rsp(4'd2, 64'h77);
    check("bad_op_d_opcode", 64'(d_opcode), 64'd1);
    check("bad_op_d_denied", 64'(d_denied), 64'd1);
    check("bad_op_d_data", 64'(d_data), 64'h77);
    fire_d();

    // Stray GrantAck on idle sink 9
    do_reset();
    check("e_pre_proto_err", 64'(proto_err), 64'd0);
    e_valid = 1'b1; e_sink = 4'd9;
    tick();
    e_valid = 1'b0;
    check("e_stray_proto_err", 64'(proto_err), 64'd1);
    check("e_stray_outstanding", 64'(outstanding), 64'd0);
    a_valid = 1'b1; a_opcode = 3'd4; a_source = 4'd9;
    #1;
    check("e_stray_entry_idle", 64'(a_ready), 64'd1);
    a_valid = 1'b0;

    // Reset with four outstanding, then a late completion
    do_reset();
    for (int s = 0; s < 4; s++) send_a(3'd0, 4'(s), 32'(s));
    send_rsp(4'd0, 64'h99);
    check("pre_rst_outstanding", 64'(outstanding), 64'd4);
    check("pre_rst_d_valid", 64'(d_valid), 64'd1);
    check("put_d_opcode", 64'(d_opcode), 64'd0);
    check("put_d_data_zero", d_data, 64'd0);
    do_reset();
    check("post_rst_outstanding", 64'(outstanding), 64'd0);
    check("post_rst_d_valid", 64'(d_valid), 64'd0);
    check("post_rst_proto_err", 64'(proto_err), 64'd0);
    send_rsp(4'd1, 64'h11);
    check("late_rsp_proto_err", 64'(proto_err), 64'd1);
    check("late_rsp_d_valid", 64'(d_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
